// File: rtl/ext_mbox_pkg.sv
// ext_mbox_pkg: command codes, handshake FSM states and status bit positions for the mailbox responder
package ext_mbox_pkg;
    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_PUSH     = 3'd1;
    localparam logic [2:0] CMD_POP      = 3'd2;
    localparam logic [2:0] CMD_FIFO_CLR = 3'd3;
    localparam logic [2:0] CMD_ACC_ADD  = 3'd4;
    localparam logic [2:0] CMD_ACC_READ = 3'd5;
    localparam logic [2:0] CMD_ACC_CLR  = 3'd6;
    localparam logic [2:0] CMD_RSVD     = 3'd7;
    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
    localparam int ST_ACK   = 7;
    localparam int ST_FULL  = 6;
    localparam int ST_EMPTY = 5;
    localparam int ST_ERR   = 4;
    localparam int ST_CARRY = 3;
endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: DEPTH-entry byte FIFO with separate occupancy count so full and empty never alias
module mbox_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clr,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ext_mailbox_responder.sv
// ext_mailbox_responder: toggle-handshaked command mailbox with byte FIFO and accumulator on the CPU ext ports
module ext_mailbox_responder
    import ext_mbox_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] OutExtWorld1,
    input  logic [7:0] OutExtWorld2,
    input  logic [7:0] OutExtWorld3,
    input  logic [7:0] OutExtWorld4,
    output logic [7:0] InpExtWorld1,
    output logic [7:0] InpExtWorld2,
    output logic [7:0] InpExtWorld3,
    output logic [7:0] InpExtWorld4
);
    localparam int AW = $clog2(DEPTH);
    state_t        state;
    logic          req_seen, ack, err, carry, err_n;
    logic [2:0]    cmd;
    logic [7:0]    opnd, acc, resp, resp_n, head, cnt8, stat;
    logic [8:0]    sum;
    logic [AW:0]   cnt;
    logic          full, empty, exec;
    logic          unused_ok;
    assign unused_ok = ^{OutExtWorld1[6:3], OutExtWorld3, OutExtWorld4};
    assign exec = state == EXEC;

    mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (Reset),
        .push (exec && cmd == CMD_PUSH),
        .pop  (exec && cmd == CMD_POP),
        .clr  (exec && cmd == CMD_FIFO_CLR),
        .din  (opnd),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(cnt)
    );

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, opnd};
        cnt8   = 8'(cnt);
        err_n  = (cmd == CMD_PUSH && full) || (cmd == CMD_POP && empty) || cmd == CMD_RSVD;
        resp_n = cmd == CMD_PUSH     ? (full ? 8'h00 : opnd) :
                 cmd == CMD_POP      ? (empty ? 8'h00 : head) :
                 cmd == CMD_ACC_ADD  ? sum[7:0] :
                 cmd == CMD_ACC_READ ? acc : 8'h00;
        stat           = '0;
        stat[ST_ACK]   = ~ack;
        stat[ST_FULL]  = full;
        stat[ST_EMPTY] = empty;
        stat[ST_ERR]   = err;
        stat[ST_CARRY] = carry;
        stat[2:0]      = cnt8 > 8'd7 ? 3'd7 : cnt8[2:0];
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= IDLE;
            req_seen     <= 1'b0;
            ack          <= 1'b0;
            err          <= 1'b0;
            carry        <= 1'b0;
            acc          <= '0;
            resp         <= '0;
            cmd          <= CMD_NOP;
            opnd         <= '0;
            InpExtWorld1 <= 8'h20;
            InpExtWorld2 <= '0;
            InpExtWorld3 <= '0;
            InpExtWorld4 <= '0;
        end else begin
            case (state)
                IDLE: if (OutExtWorld1[7] != req_seen) begin
                    cmd      <= OutExtWorld1[2:0];
                    opnd     <= OutExtWorld2;
                    req_seen <= OutExtWorld1[7];
                    state    <= EXEC;
                end
                EXEC: begin
                    err  <= err_n;
                    resp <= resp_n;
                    if (cmd == CMD_ACC_ADD) begin
                        acc   <= sum[7:0];
                        carry <= carry | sum[8];
                    end else if (cmd == CMD_ACC_CLR) begin
                        acc   <= '0;
                        carry <= 1'b0;
                    end
                    state <= ACK;
                end
                ACK: begin
                    InpExtWorld1 <= stat;
                    InpExtWorld2 <= resp;
                    InpExtWorld3 <= cnt8;
                    InpExtWorld4 <= acc;
                    ack          <= ~ack;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ext_mailbox_responder.sv
// tb_ext_mailbox_responder: directed vector table plus reset and abort sequences for the mailbox responder
module tb_ext_mailbox_responder;
    import ext_mbox_pkg::*;
    typedef struct {
        logic [2:0] cmd;
        logic [7:0] opnd;
        logic [7:0] resp;
        logic [7:0] stat;
        logic [7:0] occ;
        logic [7:0] acc;
    } vec_t;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4;
    logic [7:0] InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4;
    int         checks = 0;
    int         errors = 0;
    logic       req = 1'b0;
    logic       exp_ack = 1'b0;
    vec_t       vecs[23];

    ext_mailbox_responder #(.DEPTH(4)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .OutExtWorld1(OutExtWorld1),
        .OutExtWorld2(OutExtWorld2),
        .OutExtWorld3(OutExtWorld3),
        .OutExtWorld4(OutExtWorld4),
        .InpExtWorld1(InpExtWorld1),
        .InpExtWorld2(InpExtWorld2),
        .InpExtWorld3(InpExtWorld3),
        .InpExtWorld4(InpExtWorld4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        @(negedge clk);
        req = ~req;
        OutExtWorld2 = v.opnd;
        OutExtWorld1 = {req, 4'b0101, v.cmd};
        repeat (2) @(posedge clk);
        #1 chk("ack_early", idx, {7'd0, InpExtWorld1[7]}, {7'd0, exp_ack});
        @(posedge clk);
        #1 exp_ack = ~exp_ack;
        chk("ack", idx, {7'd0, InpExtWorld1[7]}, {7'd0, exp_ack});
        chk("resp", idx, InpExtWorld2, v.resp);
        chk("stat", idx, InpExtWorld1, {exp_ack, v.stat[6:0]});
        chk("occ", idx, InpExtWorld3, v.occ);
        chk("acc", idx, InpExtWorld4, v.acc);
    endtask

    initial begin
        vecs[0]  = '{CMD_PUSH,     8'hA5, 8'hA5, 8'h01, 8'd1, 8'h00};
        vecs[1]  = '{CMD_PUSH,     8'h3C, 8'h3C, 8'h02, 8'd2, 8'h00};
        vecs[2]  = '{CMD_POP,      8'h00, 8'hA5, 8'h01, 8'd1, 8'h00};
        vecs[3]  = '{CMD_POP,      8'h00, 8'h3C, 8'h20, 8'd0, 8'h00};
        vecs[4]  = '{CMD_PUSH,     8'h11, 8'h11, 8'h01, 8'd1, 8'h00};
        vecs[5]  = '{CMD_PUSH,     8'h22, 8'h22, 8'h02, 8'd2, 8'h00};
        vecs[6]  = '{CMD_PUSH,     8'h33, 8'h33, 8'h03, 8'd3, 8'h00};
        vecs[7]  = '{CMD_PUSH,     8'h44, 8'h44, 8'h44, 8'd4, 8'h00};
        vecs[8]  = '{CMD_PUSH,     8'h55, 8'h00, 8'h54, 8'd4, 8'h00};
        vecs[9]  = '{CMD_POP,      8'h00, 8'h11, 8'h03, 8'd3, 8'h00};
        vecs[10] = '{CMD_POP,      8'h00, 8'h22, 8'h02, 8'd2, 8'h00};
        vecs[11] = '{CMD_POP,      8'h00, 8'h33, 8'h01, 8'd1, 8'h00};
        vecs[12] = '{CMD_POP,      8'h00, 8'h44, 8'h20, 8'd0, 8'h00};
        vecs[13] = '{CMD_POP,      8'h00, 8'h00, 8'h30, 8'd0, 8'h00};
        vecs[14] = '{CMD_ACC_ADD,  8'hF0, 8'hF0, 8'h20, 8'd0, 8'hF0};
        vecs[15] = '{CMD_ACC_ADD,  8'h20, 8'h10, 8'h28, 8'd0, 8'h10};
        vecs[16] = '{CMD_ACC_ADD,  8'h01, 8'h11, 8'h28, 8'd0, 8'h11};
        vecs[17] = '{CMD_ACC_READ, 8'h00, 8'h11, 8'h28, 8'd0, 8'h11};
        vecs[18] = '{CMD_PUSH,     8'h99, 8'h99, 8'h09, 8'd1, 8'h11};
        vecs[19] = '{CMD_RSVD,     8'h5A, 8'h00, 8'h19, 8'd1, 8'h11};
        vecs[20] = '{CMD_NOP,      8'h00, 8'h00, 8'h09, 8'd1, 8'h11};
        vecs[21] = '{CMD_FIFO_CLR, 8'h00, 8'h00, 8'h28, 8'd0, 8'h11};
        vecs[22] = '{CMD_ACC_CLR,  8'h00, 8'h00, 8'h20, 8'd0, 8'h00};

        Reset = 1'b1;
        OutExtWorld1 = 8'h00;
        OutExtWorld2 = 8'h00;
        OutExtWorld3 = 8'hFF;
        OutExtWorld4 = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        chk("rst_st", 0, InpExtWorld1, 8'h20);
        chk("rst_resp", 0, InpExtWorld2, 8'h00);
        chk("rst_occ", 0, InpExtWorld3, 8'h00);
        chk("rst_acc", 0, InpExtWorld4, 8'h00);
        repeat (6) @(posedge clk);
        #1 chk("idle_st", 0, InpExtWorld1, 8'h20);

        for (int i = 0; i < 23; i++) run(vecs[i], i);

        // abort a PUSH while it is in EXEC; the request line is parked low across reset
        @(negedge clk);
        req = ~req;
        OutExtWorld2 = 8'h77;
        OutExtWorld1 = {req, 4'b0000, CMD_PUSH};
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;
        req = 1'b0;
        OutExtWorld1 = 8'h00;
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        exp_ack = 1'b0;
        chk("abort_st", 0, InpExtWorld1, 8'h20);
        chk("abort_occ", 0, InpExtWorld3, 8'h00);
        repeat (4) @(posedge clk);
        #1 chk("abort_idle", 0, InpExtWorld1, 8'h20);
        run('{CMD_PUSH, 8'h77, 8'h77, 8'h01, 8'd1, 8'h00}, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_mailbox_responder.md
# ext_mailbox_responder

External-world peripheral that sits on the far side of the RISC processor's I/O ports. It consumes commands the processor writes through its output ports (OutExtWorld1..4) and returns status and results on the processor's input ports (InpExtWorld1..4). It provides a toggle-handshaked command mailbox with a small byte FIFO and an 8-bit accumulator. Firmware drives it with OUT/IN instructions.

## Interface
- DEPTH, 4, FIFO depth in bytes; power of two, 2..128.
- clk  input  1  system clock, same clock as the processor.
- Reset  input  1  synchronous, active-high reset.
- OutExtWorld1  input  8  command: [7] request toggle, [2:0] command code, [6:3] ignored.
- OutExtWorld2  input  8  command operand (write data).
- OutExtWorld3  input  8  unused; no effect.
- OutExtWorld4  input  8  unused; no effect.
- InpExtWorld1  output  8  status: [7] ack toggle, [6] full, [5] empty, [4] err, [3] carry, [2:0] count saturated at 7.
- InpExtWorld2  output  8  response data of last completed command.
- InpExtWorld3  output  8  FIFO occupancy, full value 0..DEPTH.
- InpExtWorld4  output  8  accumulator value.

## Operation
- Command codes:
  - 0 NOP
  - 1 PUSH: operand to FIFO
  - 2 POP: FIFO head to response
  - 3 FIFO_CLR
  - 4 ACC_ADD: acc += operand
  - 5 ACC_READ: acc to response
  - 6 ACC_CLR: acc=0, carry=0
  - 7 reserved
- New request when OutExtWorld1[7] != req_seen while in IDLE.
- Firmware rule: write OutExtWorld2 before toggling OutExtWorld1[7], then poll InpExtWorld1[7] for the ack before issuing the next request.
- FSM states:
  - IDLE: on a new request, capture cmd, operand and the req bit; set req_seen to the captured req bit; go to EXEC.
  - EXEC: perform the command on FIFO and accumulator; compute err and response; go to ACK.
  - ACK: load all four InpExtWorld registers from internal state; toggle ack; go to IDLE.
- Command effects:
  - PUSH while full: err=1, FIFO unchanged, response 0x00.
  - PUSH otherwise: write at wr_ptr; response = operand.
  - POP while empty: err=1, response 0x00.
  - POP otherwise: response = head byte; advance rd_ptr.
  - FIFO_CLR: pointers and count to 0; response 0x00.
  - ACC_ADD: 9-bit sum; acc = sum[7:0] (wraps mod 256); carry |= sum[8] (sticky until ACC_CLR or Reset); response = new acc.
  - Reserved code 7: err=1, no state change, response 0x00.
  - NOP: response 0x00, err=0.
- err reflects only the last completed command. It is cleared by any successful command.
- FIFO pointers wrap modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
- Toggles arriving during EXEC or ACK are not lost: they are compared against req_seen on return to IDLE.
- A double toggle during busy nets zero change and is not detected (firmware rule above prevents this).

## Timing
- Request toggle sampled at edge N (IDLE to EXEC). EXEC at N+1. Ack and data visible after edge N+2. Fixed 3-cycle latency, within one 5-phase processor instruction.
- InpExtWorld1..4 are registers. They change only in ACK or on Reset, so firmware reads are never torn.
- Reset values:
  - InpExtWorld1 = 0x20 (empty=1).
  - InpExtWorld2/3/4 = 0x00.
  - Internal: state IDLE, req_seen 0, ack 0, FIFO empty, acc 0, carry 0.
- Reset asserted mid-operation aborts the command with no partial effect visible, and returns to IDLE the next cycle.
- If OutExtWorld1[7]=1 on the first cycle after Reset, it is treated as a new request.

## Structure
- Package ext_mbox_pkg holds:
  - command code constants
  - FSM state enum (IDLE, EXEC, ACK)
  - status bit-position constants
- Sub-module mbox_fifo:
  - DEPTH-parameterised byte FIFO with push/pop/clear, full, empty and count.
  - Registered storage, synchronous reset.
- Top-level: handshake FSM, accumulator, status and response registers.

## Test plan
- Reset, then read ports: InpExtWorld1=0x20, InpExtWorld2/3/4=0x00; no ack toggle while OutExtWorld1 is held at 0x00.
- PUSH 0xA5, 0x3C, then POP twice, each with toggle and wait for ack: responses 0xA5, 0x3C, 0xA5 (POP), 0x3C (POP). Final count 0, empty=1, err=0. Each ack exactly 3 cycles after its toggle.
- PUSH 5 bytes with DEPTH=4: fifth ack has err=1, full=1, InpExtWorld3=4. Then 5 POPs: fifth has err=1, response 0x00.
- ACC_ADD 0xF0 then ACC_ADD 0x20: acc=0x10, carry=1. ACC_ADD 0x01: acc=0x11, carry still 1. ACC_CLR: acc=0x00, carry=0.
- Issue code 7: err=1, FIFO and acc unchanged. Then NOP: err=0.
- Assert Reset during EXEC of a PUSH 0x77: count stays 0, InpExtWorld1=0x20 after reset. Toggle again after reset: a normal 3-cycle ack follows.
